// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters; ALU_ARB_ERR_EN adds rsp_err.
// Latency: request accepted at edge N, rsp_valid high after edge N+1; one operation in flight.
// Backpressure: rsp_ready low holds the response and blocks all new grants.

module alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] mode,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        case (mode)
            4'b0000: y = a + b;
            4'b0001: y = a + ~b + 8'd1;
            4'b0010: y = a & b;
            4'b0011: y = a | b;
            4'b0100: y = ~a;
            default: y = 8'h00;
        endcase
    end
endmodule

module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req0_op,
    input  logic [3:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data
`ifdef ALU_ARB_ERR_EN
    ,
    output logic       rsp_err
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_grant;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_op;
    logic       r_id;
    logic       r_rsp_id;
    logic [7:0] r_rsp_data;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_op_legal;
    logic [3:0] w_alu_mode;
    logic [7:0] w_alu_y;

    // Contended grant goes to whichever requester did not win last time.
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid && (!req1_valid || r_last_grant)) begin
                    w_grant0 = 1'b1;
                end else if (req1_valid) begin
                    w_grant1 = 1'b1;
                end
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Illegal opcodes never reach the ALU; they are forced to add and the result is zeroed.
    assign w_op_legal = (r_op <= 4'b0100);
    assign w_alu_mode = w_op_legal ? r_op : 4'b0000;

    alu u_alu (
        .a    (r_a),
        .b    (r_b),
        .mode (w_alu_mode),
        .y    (w_alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_a          <= 8'h00;
            r_b          <= 8'h00;
            r_op         <= 4'b0000;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= 8'h00;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_a          <= w_grant1 ? req1_a  : req0_a;
                r_b          <= w_grant1 ? req1_b  : req0_b;
                r_op         <= w_grant1 ? req1_op : req0_op;
                r_id         <= w_grant1;
                r_last_grant <= w_grant1;
            end
            if (r_state == EXEC) begin
                r_rsp_id   <= r_id;
                r_rsp_data <= w_op_legal ? w_alu_y : 8'h00;
            end
        end
    end

`ifdef ALU_ARB_ERR_EN
    logic r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_err <= !w_op_legal;
        end
    end

    assign rsp_err = r_rsp_err & (r_state == RESP);
`endif

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req0_ready = rst_n & w_grant0;
    assign req1_ready = rst_n & w_grant1;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: one task per scenario with inline checks.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;
`ifdef ALU_ARB_ERR_EN
    logic       rsp_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef ALU_ARB_ERR_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    task automatic do_reset;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 4'h0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 4'h0;
        @(negedge clk);
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready act=%b req=0", req0_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid act=%b req=0", rsp_valid); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL rst_id act=%b req=0", rsp_id); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL rst_data act=%h req=00", rsp_data); end
        rst_n = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL first_accept act=%b req=1", req0_ready); end
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03) begin
            bad++; $display("FAIL first_rsp act=%b/%h req=1/03", rsp_valid, rsp_data); end
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 4'b0000; rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL single_grant act=%b%b req=10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 8'hAA;
        @(negedge clk);
        total++; if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_exec act=%b/%b req=0/0", req0_ready, rsp_valid); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h08) begin
            bad++; $display("FAIL single_rsp act=%b/%b/%h req=1/0/08", rsp_valid, rsp_id, rsp_data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_pulse act=%b req=0", rsp_valid); end
    endtask

    task automatic test_contention;
        int n = 0;
        logic       exp_id;
        logic [7:0] exp_data;
        do_reset();
        req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 8'h03; req0_b = 8'h05;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 8'hF0; req1_b = 8'h3C;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            total++; if (req0_ready && req1_ready) begin bad++; $display("FAIL cont_two_ready act=11 req=not11"); end
            if (rsp_valid) begin
                exp_id   = n[0];
                exp_data = exp_id ? 8'h30 : 8'hFE;
                total++; if (rsp_id !== exp_id || rsp_data !== exp_data) begin
                    bad++; $display("FAIL cont_rsp%0d act=%b/%h req=%b/%h", n, rsp_id, rsp_data, exp_id, exp_data); end
                n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (n != 4) begin bad++; $display("FAIL cont_count act=%0d req=4", n); end
    endtask

    task automatic test_backpressure;
        int waited = 0;
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0011; req0_a = 8'h0C; req0_b = 8'h0A;
        req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 8'h01; req1_b = 8'h01;
        @(negedge clk);
        while (!rsp_valid && waited < 10) begin @(negedge clk); waited++; end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout act=%b req=1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h0E || rsp_id !== 1'b0 ||
                         req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++; $display("FAIL bp_stall%0d act=%b/%h/%b/%b%b req=1/0e/0/00",
                                i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            bad++; $display("FAIL bp_release act=%b/%b%b req=0/01", rsp_valid, req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_illegal;
        do_reset();
        req1_valid = 1'b1; req1_op = 4'b0111; req1_a = 8'h12; req1_b = 8'h34;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL ill_grant act=%b req=1", req1_ready); end
        @(posedge clk); #1; req1_valid = 1'b0;
        @(negedge clk);
        total++; if (dut.w_alu_mode !== 4'b0000) begin bad++; $display("FAIL ill_mode act=%b req=0000", dut.w_alu_mode); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_id !== 1'b1) begin
            bad++; $display("FAIL ill_rsp act=%b/%h/%b req=1/00/1", rsp_valid, rsp_data, rsp_id); end
`ifdef ALU_ARB_ERR_EN
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL ill_err act=%b req=1", rsp_err); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        int seen = 0;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 8'h01; req0_b = 8'h01;
        @(posedge clk); #1; req0_valid = 1'b0;
        #2; rst_n = 1'b0; #1;
        total++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 8'h00 || req0_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid act=%b/%b/%h/%b req=0/0/00/0", rsp_valid, rsp_id, rsp_data, req0_ready); end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_replay act=%0d req=0", seen); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL rst_rr act=%b%b req=10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_wrap_not;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 8'hFF; req0_b = 8'h02; rsp_ready = 1'b1;
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h01) begin
            bad++; $display("FAIL wrap act=%b/%h req=1/01", rsp_valid, rsp_data); end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'b0100; req0_a = 8'hA5; req0_b = 8'h00;
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin
            bad++; $display("FAIL not act=%b/%h req=1/5a", rsp_valid, rsp_data); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_wrap_not();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
